// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of an async FIFO: grants one of
// NUM_REQ producers for a burst of up to MAX_BURST words and honours wfull.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                           wclk_i,
  input  logic                           wrst_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic                           wfull_i,
  output logic                           winc_o,
  output logic [DATA_SIZE-1:0]           wdata_o,
  output logic [NUM_REQ-1:0]             grant_o,
  output logic                           busy_o
);

  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST) + 1;

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  state_e          state_q;
  logic [OW-1:0]   owner_q;
  logic [OW-1:0]   last_q;
  logic [BW-1:0]   bcnt_q;

  logic [OW-1:0]      base;
  logic [OW-1:0]      pick_idx;
  logic               pick_found;
  logic               active;
  logic               owner_vld;
  logic               xfer;
  logic               release_now;
  logic [NUM_REQ-1:0] owner_onehot;

  // Scanning from the far end lets the nearest requester after base win;
  // while bursting the current owner is the base so it ends up lowest priority.
  always_comb begin
    logic [OW-1:0] idx;
    base       = (state_q == BURST) ? owner_q : last_q;
    pick_idx   = '0;
    pick_found = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = OW'((int'(base) + k) % NUM_REQ);
      if (req_valid_i[idx]) begin
        pick_idx   = idx;
        pick_found = 1'b1;
      end
    end
  end

  // Outputs are masked while reset is asserted so an abandoned burst never writes.
  always_comb begin
    active       = (state_q == BURST) && !wrst_i;
    owner_vld    = req_valid_i[owner_q];
    xfer         = active && owner_vld && !wfull_i;
    release_now  = (state_q == BURST) &&
                   ((xfer && (bcnt_q == BW'(MAX_BURST - 1))) || !owner_vld);
    owner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
    grant_o      = active ? owner_onehot : '0;
    busy_o       = active;
    winc_o       = xfer;
    req_ready_o  = xfer ? owner_onehot : '0;
    wdata_o      = req_data_i[owner_q*DATA_SIZE +: DATA_SIZE];
  end

  always_ff @(posedge wclk_i) begin
    if (wrst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ - 1);
      bcnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            owner_q <= pick_idx;
            bcnt_q  <= '0;
            state_q <= BURST;
          end
        end
        BURST: begin
          if (release_now) begin
            last_q <= owner_q;
            if (pick_found) begin
              owner_q <= pick_idx;
              bcnt_q  <= '0;
            end else begin
              state_q <= IDLE;
            end
          end else if (xfer) begin
            bcnt_q <= bcnt_q + BW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: each scenario task drives a short
// cycle table and compares grant/winc/req_ready/wdata against hand values.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        wrst;
  logic [3:0]  reqValid;
  logic [31:0] reqData;
  logic [3:0]  reqReady;
  logic        wfull;
  logic        winc;
  logic [7:0]  wdata;
  logic [3:0]  grant;
  logic        busy;

  int compared;
  int mismatched;

  logic [7:0] wordOf [4];

  fifo_wr_arbiter #(
    .NUM_REQ  (4),
    .DATA_SIZE(8),
    .MAX_BURST(4)
  ) dut (
    .wclk_i     (clk),
    .wrst_i     (wrst),
    .req_valid_i(reqValid),
    .req_data_i (reqData),
    .req_ready_o(reqReady),
    .wfull_i    (wfull),
    .winc_o     (winc),
    .wdata_o    (wdata),
    .grant_o    (grant),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Puts the DUT in a known IDLE state; returns just after the reset edge.
  task automatic applyReset();
    @(negedge clk);
    wrst     = 1'b1;
    reqValid = 4'b0000;
    wfull    = 1'b0;
    @(posedge clk);
    #1;
    wrst = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] expGrant [4];
    logic       rstTab   [4];
    expGrant = '{4'b0000, 4'b0000, 4'b0000, 4'b0001};
    rstTab   = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 4; c++) begin
      wrst     = rstTab[c];
      reqValid = 4'b1111;
      wfull    = 1'b0;
      @(negedge clk);
      compared++;
      if (grant !== expGrant[c]) begin
        mismatched++;
        $display("[TB] FAIL reset_grant c=%0d got=%b want=%b", c, grant, expGrant[c]);
      end
      compared++;
      if (winc !== (c == 3)) begin
        mismatched++;
        $display("[TB] FAIL reset_winc c=%0d got=%b want=%b", c, winc, (c == 3));
      end
      if (c < 2) begin
        compared++;
        if (busy !== 1'b0 || reqReady !== 4'b0000) begin
          mismatched++;
          $display("[TB] FAIL reset_quiet c=%0d busy=%b ready=%b want 0/0000", c, busy, reqReady);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_fairness();
    int         writes;
    logic [3:0] eg;
    int         own;
    writes = 0;
    applyReset();
    reqValid = 4'b1111;
    for (int c = 0; c < 18; c++) begin
      @(negedge clk);
      own = (c == 0) ? 0 : ((c - 1) / 4) % 4;
      eg  = (c == 0) ? 4'b0000 : (4'b0001 << own);
      compared++;
      if (grant !== eg) begin
        mismatched++;
        $display("[TB] FAIL fair_grant c=%0d got=%b want=%b", c, grant, eg);
      end
      compared++;
      if (reqReady !== eg) begin
        mismatched++;
        $display("[TB] FAIL fair_ready c=%0d got=%b want=%b", c, reqReady, eg);
      end
      if (c > 0) begin
        compared++;
        if (wdata !== wordOf[own]) begin
          mismatched++;
          $display("[TB] FAIL fair_wdata c=%0d got=%h want=%h", c, wdata, wordOf[own]);
        end
      end
      if (c < 17 && winc === 1'b1) writes++;
      @(posedge clk);
      #1;
    end
    compared++;
    if (writes !== 16) begin
      mismatched++;
      $display("[TB] FAIL fair_writes got=%0d want=16", writes);
    end
  endtask

  task automatic test_backpressure();
    logic fullTab [8];
    logic expWinc [8];
    int   writes;
    fullTab = '{0, 0, 0, 1, 1, 1, 0, 0};
    expWinc = '{0, 1, 1, 0, 0, 0, 1, 1};
    writes  = 0;
    applyReset();
    for (int c = 0; c < 8; c++) begin
      reqValid = 4'b0001;
      wfull    = fullTab[c];
      @(negedge clk);
      compared++;
      if (winc !== expWinc[c]) begin
        mismatched++;
        $display("[TB] FAIL bp_winc c=%0d got=%b want=%b", c, winc, expWinc[c]);
      end
      compared++;
      if (reqReady !== (expWinc[c] ? 4'b0001 : 4'b0000)) begin
        mismatched++;
        $display("[TB] FAIL bp_ready c=%0d got=%b want=%b", c, reqReady, (expWinc[c] ? 4'b0001 : 4'b0000));
      end
      compared++;
      if (grant !== ((c == 0) ? 4'b0000 : 4'b0001)) begin
        mismatched++;
        $display("[TB] FAIL bp_grant c=%0d got=%b want=%b", c, grant, ((c == 0) ? 4'b0000 : 4'b0001));
      end
      if (winc === 1'b1) writes++;
      @(posedge clk);
      #1;
    end
    wfull = 1'b0;
    compared++;
    if (writes !== 4) begin
      mismatched++;
      $display("[TB] FAIL bp_writes got=%0d want=4", writes);
    end
  endtask

  task automatic test_sole_requester();
    logic [3:0] validTab [9];
    logic [3:0] expGrant [9];
    logic       expWinc  [9];
    validTab = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
    expGrant = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0};
    expWinc  = '{0, 1, 1, 1, 1, 1, 1, 0, 0};
    applyReset();
    for (int c = 0; c < 9; c++) begin
      reqValid = validTab[c];
      @(negedge clk);
      compared++;
      if (grant !== expGrant[c] || winc !== expWinc[c]) begin
        mismatched++;
        $display("[TB] FAIL sole c=%0d grant=%b winc=%b want %b/%b", c, grant, winc, expGrant[c], expWinc[c]);
      end
      if (expWinc[c]) begin
        compared++;
        if (wdata !== wordOf[2]) begin
          mismatched++;
          $display("[TB] FAIL sole_wdata c=%0d got=%h want=%h", c, wdata, wordOf[2]);
        end
      end
      @(posedge clk);
      #1;
    end
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL sole_idle busy got=%b want=0", busy);
    end
  endtask

  task automatic test_early_drop();
    logic [3:0] validTab [4];
    logic [3:0] expGrant [4];
    logic       expWinc  [4];
    validTab = '{4'b0010, 4'b0010, 4'b1000, 4'b1000};
    expGrant = '{4'b0000, 4'b0010, 4'b0010, 4'b1000};
    expWinc  = '{0, 1, 0, 1};
    applyReset();
    for (int c = 0; c < 4; c++) begin
      reqValid = validTab[c];
      @(negedge clk);
      compared++;
      if (grant !== expGrant[c] || winc !== expWinc[c]) begin
        mismatched++;
        $display("[TB] FAIL drop c=%0d grant=%b winc=%b want %b/%b", c, grant, winc, expGrant[c], expWinc[c]);
      end
      if (c == 3) begin
        compared++;
        if (wdata !== wordOf[3] || reqReady !== 4'b1000) begin
          mismatched++;
          $display("[TB] FAIL drop_req3 wdata=%h ready=%b want %h/1000", wdata, reqReady, wordOf[3]);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_midburst_reset();
    logic [3:0] validTab [5];
    logic       rstTab   [5];
    logic [3:0] expGrant [5];
    logic       expWinc  [5];
    validTab = '{4'b0100, 4'b0100, 4'b1111, 4'b1111, 4'b1111};
    rstTab   = '{0, 0, 1, 0, 0};
    expGrant = '{4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0001};
    expWinc  = '{0, 1, 0, 0, 1};
    applyReset();
    for (int c = 0; c < 5; c++) begin
      reqValid = validTab[c];
      wrst     = rstTab[c];
      @(negedge clk);
      compared++;
      if (grant !== expGrant[c] || winc !== expWinc[c]) begin
        mismatched++;
        $display("[TB] FAIL midrst c=%0d grant=%b winc=%b want %b/%b", c, grant, winc, expGrant[c], expWinc[c]);
      end
      @(posedge clk);
      #1;
    end
    wrst = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    wordOf     = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    reqData    = {wordOf[3], wordOf[2], wordOf[1], wordOf[0]};
    wrst       = 1'b1;
    reqValid   = 4'b1111;
    wfull      = 1'b0;
    test_reset();
    test_fairness();
    test_backpressure();
    test_sole_requester();
    test_early_drop();
    test_midburst_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
